// File: rtl/n64_poll_tx.sv
// Console-side N64 poll transmitter: sends a command byte plus stop bit on the open-drain
// data line, then holds a response window open for the downstream receiver.
module n64_poll_tx #(
   parameter int         CYC_PER_US     = 10,
   parameter int         POLL_PERIOD_US = 1000,
   parameter logic [7:0] CMD            = 8'h01,
   parameter int         RX_TIMEOUT_US  = 200
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        trigger,
   output logic        line_drive_low,
   output logic        rx_enable,
   input  logic        rx_done,
   output logic        busy,
   output logic        timeout,
   output logic [15:0] poll_count
);

   localparam int BIT_CYC    = 4 * CYC_PER_US;
   localparam int PERIOD_CYC = POLL_PERIOD_US * CYC_PER_US;
   localparam int RX_CYC     = RX_TIMEOUT_US * CYC_PER_US;
   localparam int CW         = $clog2(BIT_CYC);
   localparam int RW         = (RX_CYC > 1) ? $clog2(RX_CYC) : 1;
   localparam int PW         = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

   localparam logic [CW-1:0] BIT_LAST    = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] STOP_LAST   = CW'(CYC_PER_US - 1);
   localparam logic [CW-1:0] LOW_ZERO    = CW'(3 * CYC_PER_US);
   localparam logic [CW-1:0] LOW_ONE     = CW'(CYC_PER_US);
   localparam logic [RW-1:0] RX_LAST     = RW'(RX_CYC - 1);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYC - 1);

   if (CYC_PER_US < 2) begin : g_cyc_check
      $error("n64_poll_tx: CYC_PER_US must be at least 2");
   end
   if (RX_TIMEOUT_US < 1) begin : g_rx_check
      $error("n64_poll_tx: RX_TIMEOUT_US must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, TX_BIT, TX_STOP, RX} state_t;

   state_t        state_q, state_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [CW-1:0] cyc_q, cyc_d, cyc_inc, low_len;
   logic [7:0]    shreg_q, shreg_d;
   logic [RW-1:0] rx_cnt_q, rx_cnt_d;
   logic [PW-1:0] timer_q;
   logic          pending_q;
   logic          period_hit, launch;
   logic          line_d, rx_en_d, busy_d, tmo_d;

   assign cyc_inc    = cyc_q + CW'(1);
   assign low_len    = shreg_q[7] ? LOW_ONE : LOW_ZERO;
   assign period_hit = (PERIOD_CYC > 0) && enable && (timer_q == PERIOD_LAST);

   // Single-entry request flag: triggers and period ticks arriving while it is set
   // (or while a poll is in flight) merge into one pending poll.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_q   <= '0;
         pending_q <= 1'b0;
      end else if (!enable) begin
         timer_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         timer_q <= (period_hit || PERIOD_CYC == 0) ? '0 : timer_q + PW'(1);
         if (trigger || period_hit) pending_q <= 1'b1;
         else if (launch)           pending_q <= 1'b0;
      end
   end

   // NOTE: every value this block writes gets a default first, so no latches are inferred.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      cyc_d     = cyc_q;
      shreg_d   = shreg_q;
      rx_cnt_d  = rx_cnt_q;
      line_d    = 1'b0;
      rx_en_d   = 1'b0;
      busy_d    = busy;
      tmo_d     = 1'b0;
      launch    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pending_q && enable) begin
               launch    = 1'b1;
               state_d   = TX_BIT;
               shreg_d   = CMD;
               bit_idx_d = '0;
               cyc_d     = '0;
               line_d    = 1'b1;
               busy_d    = 1'b1;
            end
         end
         TX_BIT: begin
            if (cyc_q == BIT_LAST) begin
               cyc_d  = '0;
               line_d = 1'b1;
               if (bit_idx_q == 3'd7) begin
                  state_d = TX_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shreg_d   = {shreg_q[6:0], 1'b0};
               end
            end else begin
               cyc_d  = cyc_inc;
               line_d = (cyc_inc < low_len);
            end
         end
         TX_STOP: begin
            if (cyc_q == STOP_LAST) begin
               state_d  = RX;
               rx_cnt_d = '0;
               rx_en_d  = 1'b1;
            end else begin
               cyc_d  = cyc_inc;
               line_d = 1'b1;
            end
         end
         RX: begin
            // rx_done is checked first so it wins over a same-cycle expiry.
            if (rx_done) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (rx_cnt_q == RX_LAST) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               tmo_d   = 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q + RW'(1);
               rx_en_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the pad control is a register with async reset, so reset releases the line
   // immediately without waiting for a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         bit_idx_q      <= '0;
         cyc_q          <= '0;
         shreg_q        <= '0;
         rx_cnt_q       <= '0;
         line_drive_low <= 1'b0;
         rx_enable      <= 1'b0;
         busy           <= 1'b0;
         timeout        <= 1'b0;
         poll_count     <= '0;
      end else begin
         state_q        <= state_d;
         bit_idx_q      <= bit_idx_d;
         cyc_q          <= cyc_d;
         shreg_q        <= shreg_d;
         rx_cnt_q       <= rx_cnt_d;
         line_drive_low <= line_d;
         rx_enable      <= rx_en_d;
         busy           <= busy_d;
         timeout        <= tmo_d;
         if (launch) poll_count <= poll_count + 16'd1;
      end
   end

endmodule
